// File: rtl/program_counter.sv
// program_counter: architectural PC register loaded on the falling clock edge; define PC_ALIGN_CHECK_EN for word alignment and the pc_misaligned flag
module program_counter #(
  parameter int WIDTH = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  input  logic [WIDTH-1:0] pc_in,
`ifdef PC_ALIGN_CHECK_EN
  output logic pc_misaligned,
`endif
  output logic [WIDTH-1:0] pc_out
);
  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VALUE);
  logic [WIDTH-1:0] pc_q = RST_PC;
  assign pc_out = pc_q;
`ifdef PC_ALIGN_CHECK_EN
  logic mis_q = 1'b0;
  assign pc_misaligned = mis_q;
  // falling-edge load forcing word alignment, flagging dropped low bits
  always_ff @(negedge clk) begin
    pc_q <= reset ? RST_PC : {pc_in[WIDTH-1:2], 2'b00};
    mis_q <= !reset && (pc_in[1:0] != 2'b00);
  end
`else
  // falling-edge load so the PC is stable through the following high phase
  always_ff @(negedge clk) begin
    pc_q <= reset ? RST_PC : pc_in;
  end
`endif
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: table-driven, hand-written and randomized checks of program_counter
module tb_program_counter;
  logic clk = 1'b1;
  logic reset = 1'b0;
  logic [31:0] pc_in = 32'd4;
  logic [31:0] pc_out;
  int checks = 0;
  int passed = 0;
`ifdef PC_ALIGN_CHECK_EN
  logic pc_misaligned;
  program_counter dut (.clk(clk), .reset(reset), .pc_in(pc_in), .pc_misaligned(pc_misaligned), .pc_out(pc_out));
`else
  program_counter dut (.clk(clk), .reset(reset), .pc_in(pc_in), .pc_out(pc_out));
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic [31:0] din;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) $display("FAIL %s: got %h expected %h", name, got, want);
    else passed++;
  endtask

  task automatic step(input logic r, input logic [31:0] d);
    @(posedge clk);
    #1;
    reset = r;
    pc_in = d;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_pc(input logic r, input logic [31:0] d);
`ifdef PC_ALIGN_CHECK_EN
    return r ? 32'h0 : (d / 4) * 4;
`else
    return r ? 32'h0 : d;
`endif
  endfunction

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] d;
    logic r;
    #1 reset = 1'b1;
    #1 check("powerup_no_edge", pc_out, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    check("powerup_mis", {31'b0, pc_misaligned}, 32'h0);
`endif
    @(negedge clk);
    #1 check("reset_edge1", pc_out, 32'h0);
    step(1'b1, 32'd4);
    check("reset_edge2", pc_out, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc_in = 32'd4;
    #1 check("no_load_on_rise", pc_out, 32'h0);
    @(negedge clk);
    #1 check("first_load", pc_out, model_pc(1'b0, 32'd4));
    vecs[0] = '{1'b0, 32'h0000_0008, 32'h0000_0008};
    vecs[1] = '{1'b0, 32'h8000_0000, 32'h8000_0000};
    vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'h1234_5678, 32'h0000_0000};
    vecs[6] = '{1'b0, 32'h1234_5678, 32'h1234_5678};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[9] = '{1'b0, 32'h0000_0100, 32'h0000_0100};
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].din);
`ifdef PC_ALIGN_CHECK_EN
      exp_pc = vecs[i].exp_pc & 32'hFFFF_FFFC;
      check($sformatf("vec%0d_mis", i), {31'b0, pc_misaligned}, {31'b0, !vecs[i].rst && vecs[i].din[1:0] != 2'b00});
`else
      exp_pc = vecs[i].exp_pc;
`endif
      check($sformatf("vec%0d", i), pc_out, exp_pc);
      pc_in = $urandom;
      reset = $urandom_range(0, 1) == 1;
      #2 check($sformatf("vec%0d_midtoggle", i), pc_out, exp_pc);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    pc_in = 32'h40;
    #1 check("reset_mid_hold", pc_out, 32'h100);
    @(negedge clk);
    #1 check("reset_mid_take", pc_out, 32'h0);
    step(1'b0, 32'h8);
    check("reset_release", pc_out, 32'h8);
    step(1'b1, 32'hxxxx_xxxx);
    check("x_under_reset", pc_out, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    check("x_under_reset_mis", {31'b0, pc_misaligned}, 32'h0);
    step(1'b0, 32'h6);
    check("align_pc", pc_out, 32'h4);
    check("align_mis_set", {31'b0, pc_misaligned}, 32'h1);
    step(1'b0, 32'h8);
    check("align_mis_clr", {31'b0, pc_misaligned}, 32'h0);
`endif
    exp_pc = 32'h0;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9) == 0;
      case ($urandom_range(0, 4))
        0: d = 32'hFFFF_FFFF;
        1: d = 32'hFFFF_FFFC;
        default: d = $urandom;
      endcase
      step(r, d);
      exp_pc = model_pc(r, d);
      check("random", pc_out, exp_pc);
`ifdef PC_ALIGN_CHECK_EN
      check("random_mis", {31'b0, pc_misaligned}, {31'b0, !r && (d % 4 != 0)});
`endif
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
